uart_tx: RTL and testbench
==========================

# uart_tx

UART serializer with a one-entry transmit holding register (THR) and a transmit shift register (TSR). Sits downstream of the baud clock generator: consumes its per-bit `transmit_edge` strobe and returns `transmit_clk_clr` to phase-align the baud counter at the start of each frame. Serializes 5–8 data bits LSB first on `txd`, with optional parity and 1 or 2 stop bits, under 16550-style line-control fields.

## Interface
Parameters: none. Data path fixed at 8 bits.

- `pclk` in 1: clock; one clock.
- `preset` in 1: reset; synchronous, active-high.
- `transmit_edge` in 1: one-cycle bit-period strobe from the clock generator.
- `transmit_clk_clr` out 1: one-cycle pulse that restarts the transmit baud counter.
- `thr_data` in 8: byte to transmit.
- `thr_valid` in 1: write request for `thr_data`.
- `thr_ready` out 1: THR empty; a write transfers when `thr_valid & thr_ready`.
- `wls` in 2: word length select; 00=5, 01=6, 10=7, 11=8 bits.
- `stb` in 1: 0 = 1 stop bit, 1 = 2 stop bits (for all word lengths; 1.5 not supported).
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sp` in 1: stick parity.
- `bc` in 1: break control; forces `txd` low.
- `txd` out 1: serial output; idles high.
- `tx_busy` out 1: TSR not idle (state ≠ IDLE).
- `tx_empty` out 1: THR empty and state = IDLE.
- `tx_done` out 1: one-cycle pulse when the last stop bit ends.

## Operation
- **THR write:** if `thr_valid & thr_ready` at edge N, the THR holds the byte and `thr_ready` = 0 from N. `thr_ready` is registered and never depends on `thr_valid` in the same cycle.
- **TSR load:** occurs when the THR is full at the start of a cycle and the FSM is in IDLE, or at the `transmit_edge` that ends the final stop bit.
  - Load latches `thr_data`, `wls`, `stb`, `pen`, `eps`, `sp`. Later changes to these inputs do not affect the frame in flight.
  - Load frees the THR.
- **FSM states:**
  - IDLE: `txd` = 1. `transmit_edge` is ignored.
  - IDLE -> START on load, not at an edge. `transmit_clk_clr` = 1 for exactly one cycle (the first START cycle).
  - START -> DATA on `transmit_edge`. `transmit_edge` is ignored in the cycle `transmit_clk_clr` = 1.
  - DATA: the bit counter runs 0..wls+4. Bit k drives `txd` = data[k]. At the last bit, advance to PARITY if `pen`, else STOP.
  - PARITY -> STOP on `transmit_edge`.
  - STOP: `txd` = 1 for 1 or 2 bit periods.
  - At the ending `transmit_edge`, `tx_done` = 1. Next state is START if the THR is full (back-to-back, no idle bit, no `transmit_clk_clr`), else IDLE.
- **Parity value:** P = XOR of the wls+5 active data bits only; upper bits are ignored.
  - `sp` = 0, `eps` = 1: P (even).
  - `sp` = 0, `eps` = 0: ~P (odd).
  - `sp` = 1: ~`eps`.
- **Break:** `bc` = 1 forces `txd` = 0 combinationally over the registered value. The FSM keeps running unchanged.
- **Output register:** `txd` comes from a register (before the `bc` gating). No glitches from the FSM decode.

## Timing
- **Reset values:** `txd` = 1, `thr_ready` = 1, `tx_busy` = 0, `tx_empty` = 1, `tx_done` = 0, `transmit_clk_clr` = 0. THR and TSR are cleared; FSM = IDLE.
- **Latency:** handshake in cycle C, then in cycle C+2 `txd` falls (start bit) and `transmit_clk_clr` = 1.
- **Bit duration:** each bit (start, data, parity, stop) ends at the next honoured `transmit_edge`. Frame length is 1 + (wls+5) + pen + (stb+1) edges.
- **Simultaneous events:**
  - THR write in the same cycle the TSR loads from the THR: not possible, because `thr_ready` = 0 while the THR is full.
  - A write in the cycle after the load is accepted. It is the pending byte for back-to-back transmission.
- **Reset mid-frame:** from the next cycle the block is at reset values, and any byte in the THR or TSR is discarded.

## Test plan
- **8N1, 0xA5** (wls=11, pen=0, stb=0): `txd` = 0,1,0,1,0,0,1,0,1,1 across 10 `transmit_edge` periods. `tx_done` pulses at the 10th edge; `transmit_clk_clr` pulses once, two cycles after the handshake.
- **7E2, 0x55** (wls=10, pen=1, eps=1): data 1,0,1,0,1,0,1, parity 0, stop 1,1; 11 bits total.
- **5O1, 0xFF** (wls=00, pen=1, eps=0): data 1,1,1,1,1, parity 0. Bits 7:5 are not transmitted; frame is 8 bits.
- **Back-to-back 0x01 then 0x80** (8N1), second byte written during the first frame's data bits: the second start bit begins at the edge ending the first stop bit, with no idle bit. `transmit_clk_clr` pulses only once and `tx_done` pulses twice. `tx_empty` = 1 only after the second stop bit.
- **Stick parity and break:** sp=1, eps=0 gives parity bit 1 regardless of data. `bc` = 1 asserted mid-frame drives `txd` = 0 the same cycle, and `tx_done` still arrives at the normal edge count.
- **Reset mid-frame:** `preset` during data bit 3 with a byte pending in the THR. Next cycle: `txd` = 1, `thr_ready` = 1, `tx_busy` = 0. No further frame is transmitted.

Source files
------------

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//
// UART serializer with a one-entry transmit holding register (THR) and a
// transmit shift register (TSR). Frames are start bit, 5..8 data bits (LSB
// first), optional parity, then 1 or 2 stop bits. Bit timing comes from an
// external baud generator through the per-bit transmit_edge strobe; the
// transmitter pulses transmit_clk_clr at the start of a frame from idle so the
// generator is phase-aligned to the start bit.
//
// Ports
//   pclk, preset       clock, synchronous active-high reset
//   transmit_edge      one-cycle bit-period strobe from the baud generator
//   transmit_clk_clr   one-cycle pulse restarting the baud counter
//   thr_data/valid     byte write into the THR
//   thr_ready          THR empty (registered, independent of thr_valid)
//   wls, stb, pen,
//   eps, sp            line control, latched into the frame at TSR load
//   bc                 break: forces txd low, FSM keeps running
//   txd                serial output, idles high
//   tx_busy            frame in progress
//   tx_empty           THR empty and transmitter idle
//   tx_done            one-cycle pulse after the last stop bit ends
// ----------------------------------------------------------------------------
module uart_tx (
    input  logic       pclk,
    input  logic       preset,
    input  logic       transmit_edge,
    output logic       transmit_clk_clr,
    input  logic [7:0] thr_data,
    input  logic       thr_valid,
    output logic       thr_ready,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       bc,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_empty,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Mask of the active data bits for a word length select.
    function automatic logic [7:0] word_mask(input logic [1:0] w);
        word_mask = 8'hFF >> (3'd3 - {1'b0, w});
    endfunction

    // Parity bit for the active data bits under the latched line control.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] w,
                                        input logic e, input logic s);
        logic p;
        p = ^(d & word_mask(w));
        if (s)
            parity_bit = ~e;
        else if (e)
            parity_bit = p;
        else
            parity_bit = ~p;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] thr_q, thr_d;
    logic       thr_full_q, thr_full_d;
    logic [7:0] tsr_q, tsr_d;
    logic [1:0] frm_wls_q, frm_wls_d;
    logic       frm_stb_q, frm_stb_d;
    logic       frm_pen_q, frm_pen_d;
    logic       frm_eps_q, frm_eps_d;
    logic       frm_sp_q, frm_sp_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       txd_q, txd_d;
    logic       clr_q, clr_d;
    logic       done_q, done_d;

    logic       edge_ok;
    logic       last_bit;
    logic       last_stop;
    logic       load;

    // The strobe is ignored in the cycle the baud counter is being restarted.
    assign edge_ok   = transmit_edge & ~clr_q;
    assign last_bit  = (bit_cnt_q == ({1'b0, frm_wls_q} + 3'd4));
    assign last_stop = (stop_cnt_q == frm_stb_q);
    assign load      = thr_full_q &
                       ((state_q == S_IDLE) |
                        ((state_q == S_STOP) & edge_ok & last_stop));

    // State and datapath registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= S_IDLE;
            thr_q      <= '0;
            thr_full_q <= 1'b0;
            tsr_q      <= '0;
            frm_wls_q  <= '0;
            frm_stb_q  <= 1'b0;
            frm_pen_q  <= 1'b0;
            frm_eps_q  <= 1'b0;
            frm_sp_q   <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            tsr_q      <= tsr_d;
            frm_wls_q  <= frm_wls_d;
            frm_stb_q  <= frm_stb_d;
            frm_pen_q  <= frm_pen_d;
            frm_eps_q  <= frm_eps_d;
            frm_sp_q   <= frm_sp_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        thr_full_d = thr_full_q;
        tsr_d      = tsr_q;
        frm_wls_d  = frm_wls_q;
        frm_stb_d  = frm_stb_q;
        frm_pen_d  = frm_pen_q;
        frm_eps_d  = frm_eps_q;
        frm_sp_d   = frm_sp_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        // A write and a load can never coincide: load needs a full THR,
        // a write needs an empty one.
        if (thr_valid && !thr_full_q) begin
            thr_d      = thr_data;
            thr_full_d = 1'b1;
        end
        if (load) begin
            thr_full_d = 1'b0;
            tsr_d      = thr_q;
            frm_wls_d  = wls;
            frm_stb_d  = stb;
            frm_pen_d  = pen;
            frm_eps_d  = eps;
            frm_sp_d   = sp;
        end

        case (state_q)
            S_IDLE: begin
                if (thr_full_q)
                    state_d = S_START;
            end
            S_START: begin
                if (edge_ok) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (edge_ok) begin
                    if (last_bit) begin
                        state_d    = frm_pen_q ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (edge_ok) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (edge_ok) begin
                    if (last_stop)
                        state_d = thr_full_q ? S_START : S_IDLE;
                    else
                        stop_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: txd is decoded from the next state so the line changes
    // in the cycle right after the edge that ends a bit, glitch-free.
    always_comb begin
        txd_d  = 1'b1;
        clr_d  = load & (state_q == S_IDLE);
        done_d = (state_q == S_STOP) & edge_ok & last_stop;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tsr_q[bit_cnt_d];
            S_PARITY: txd_d = parity_bit(tsr_q, frm_wls_q, frm_eps_q, frm_sp_q);
            default:  txd_d = 1'b1;
        endcase
    end

    assign txd              = txd_q & ~bc;
    assign thr_ready        = ~thr_full_q;
    assign tx_busy          = (state_q != S_IDLE);
    assign tx_empty         = ~thr_full_q & (state_q == S_IDLE);
    assign tx_done          = done_q;
    assign transmit_clk_clr = clr_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
//
// Scoreboard bench for uart_tx. Each accepted byte pushes its expected frame
// (list of line levels, one per bit period) into a queue. A monitor acts as
// a receiver: it detects the start bit on txd, pops the expected frame and
// compares txd at every honoured transmit_edge, plus tx_busy, tx_done and
// transmit_clk_clr every cycle. A simple baud generator, restarted by
// transmit_clk_clr, drives transmit_edge every 4 cycles.
// ----------------------------------------------------------------------------
module tb_uart_tx;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       transmit_edge = 1'b0;
    logic       transmit_clk_clr;
    logic [7:0] thr_data = 8'h00;
    logic       thr_valid = 1'b0;
    logic       thr_ready;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       bc = 1'b0;
    logic       txd;
    logic       tx_busy;
    logic       tx_empty;
    logic       tx_done;

    always #5 pclk = ~pclk;

    uart_tx dut (
        .pclk             (pclk),
        .preset           (preset),
        .transmit_edge    (transmit_edge),
        .transmit_clk_clr (transmit_clk_clr),
        .thr_data         (thr_data),
        .thr_valid        (thr_valid),
        .thr_ready        (thr_ready),
        .wls              (wls),
        .stb              (stb),
        .pen              (pen),
        .eps              (eps),
        .sp               (sp),
        .bc               (bc),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .tx_empty         (tx_empty),
        .tx_done          (tx_done)
    );

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    frame_t sb_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     clr_cnt = 0;
    int     done_cnt = 0;
    logic   mon_in_frame = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference: the frame as a list of line levels.
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] w,
                                     input logic s2, input logic p_en,
                                     input logic e, input logic stick);
        frame_t f;
        int     n;
        logic   par;
        f.bits = '0;
        f.len  = 0;
        n      = int'(w) + 5;
        par    = 1'b0;
        f.bits[f.len] = 1'b0;
        f.len++;
        for (int i = 0; i < n; i++) begin
            f.bits[f.len] = d[i];
            par = par ^ d[i];
            f.len++;
        end
        if (p_en) begin
            f.bits[f.len] = stick ? ~e : (e ? par : ~par);
            f.len++;
        end
        for (int i = 0; i < (s2 ? 2 : 1); i++) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Write one byte; returns just after the handshake edge.
    task automatic send(input logic [7:0] d, input logic [1:0] w, input logic s2,
                        input logic p_en, input logic e, input logic stick);
        int t = 0;
        thr_data  = d;
        wls       = w;
        stb       = s2;
        pen       = p_en;
        eps       = e;
        sp        = stick;
        thr_valid = 1'b1;
        while (!thr_ready && t < 2000) begin
            @(posedge pclk);
            #1;
            t++;
        end
        if (!thr_ready) begin
            n_checks++;
            $display("FAIL send_timeout: thr_ready stayed %b, required 1", thr_ready);
            thr_valid = 1'b0;
            return;
        end
        sb_q.push_back(model(d, w, s2, p_en, e, stick));
        @(posedge pclk);
        #1;
        thr_valid = 1'b0;
    endtask

    // Wait for the THR to be freed by a TSR load, then scramble the line
    // control and data inputs to show the frame in flight ignores them.
    task automatic wait_load();
        int t = 0;
        do begin
            @(posedge pclk);
            #1;
            t++;
        end while (!thr_ready && t < 2000);
        if (!thr_ready) begin
            n_checks++;
            $display("FAIL load_timeout: thr_ready stayed %b, required 1", thr_ready);
        end
        thr_data = 8'($urandom);
        wls      = 2'($urandom);
        stb      = 1'($urandom);
        pen      = 1'($urandom);
        eps      = 1'($urandom);
        sp       = 1'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || mon_in_frame || !thr_ready) && t < 3000) begin
            @(posedge pclk);
            #1;
            t++;
        end
        if (t >= 3000) begin
            n_checks++;
            $display("FAIL idle_timeout: %0d frames still queued", sb_q.size());
        end
        cycles(2);
    endtask

    // Baud generator: edge every 4 cycles, restarted by transmit_clk_clr.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge pclk);
            #1;
            if (preset) begin
                cnt = 0;
                transmit_edge = 1'b0;
            end else begin
                transmit_edge = (cnt == 3);
                cnt = transmit_clk_clr ? 0 : (cnt + 1) % 4;
            end
        end
    end

    // Monitor: receiver-style frame checker.
    initial begin
        frame_t cur;
        int     idx = 0;
        logic   first = 1'b0;
        logic   done_exp = 1'b0;
        logic   prev_end = 1'b0;
        logic   stray = 1'b0;
        cur.bits = '0;
        cur.len  = 0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                mon_in_frame = 1'b0;
                done_exp     = 1'b0;
                prev_end     = 1'b0;
                stray        = 1'b0;
                sb_q.delete();
                continue;
            end
            if (!mon_in_frame && txd === 1'b0) begin
                if (sb_q.size() == 0) begin
                    if (!stray) begin
                        n_checks++;
                        $display("FAIL unexpected_frame: txd=%b with no byte queued at t=%0t",
                                 txd, $time);
                    end
                    stray = 1'b1;
                end else begin
                    cur          = sb_q.pop_front();
                    mon_in_frame = 1'b1;
                    first        = 1'b1;
                    idx          = 0;
                end
            end
            if (txd === 1'b1)
                stray = 1'b0;
            check("tx_busy", tx_busy, mon_in_frame);
            check("transmit_clk_clr", transmit_clk_clr, mon_in_frame && first && !prev_end);
            check("tx_done", tx_done, done_exp);
            if (transmit_clk_clr)
                clr_cnt++;
            if (tx_done)
                done_cnt++;
            done_exp = 1'b0;
            prev_end = 1'b0;
            if (mon_in_frame) begin
                if (transmit_edge && !first) begin
                    check($sformatf("txd_bit%0d", idx), txd, bc ? 1'b0 : cur.bits[idx]);
                    idx++;
                    if (idx == cur.len) begin
                        mon_in_frame = 1'b0;
                        done_exp     = 1'b1;
                        prev_end     = 1'b1;
                    end
                end
                first = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int c0;
        int d0;
        cycles(3);
        preset = 1'b0;
        @(negedge pclk);
        check("reset_txd", txd, 1'b1);
        check("reset_thr_ready", thr_ready, 1'b1);
        check("reset_tx_busy", tx_busy, 1'b0);
        check("reset_tx_empty", tx_empty, 1'b1);
        check("reset_tx_done", tx_done, 1'b0);
        check("reset_clk_clr", transmit_clk_clr, 1'b0);
        cycles(1);

        // 8N1 0xA5 with handshake-to-start latency
        c0 = clr_cnt;
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        check("lat_c1_txd", txd, 1'b1);
        check("lat_c1_clr", transmit_clk_clr, 1'b0);
        @(negedge pclk);
        check("lat_c2_txd", txd, 1'b0);
        check("lat_c2_clr", transmit_clk_clr, 1'b1);
        wait_load();
        wait_idle();
        check_int("8n1_clr_pulses", clr_cnt - c0, 1);

        // 7E2 0x55 and 5O1 0xFF
        send(8'h55, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_load();
        wait_idle();
        send(8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_load();
        wait_idle();

        // Back-to-back 0x01 then 0x80, second write during data bits
        c0 = clr_cnt;
        d0 = done_cnt;
        send(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_load();
        cycles(12);
        send(8'h80, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        check("b2b_tx_empty_pending", tx_empty, 1'b0);
        wait_load();
        @(negedge pclk);
        check("b2b_tx_empty_second_frame", tx_empty, 1'b0);
        wait_idle();
        check("b2b_tx_empty_end", tx_empty, 1'b1);
        check_int("b2b_clr_pulses", clr_cnt - c0, 1);
        check_int("b2b_done_pulses", done_cnt - d0, 2);

        // Stick parity (sp=1, eps=0 -> parity 1) with break mid-frame
        d0 = done_cnt;
        send(8'($urandom), 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_load();
        cycles(12);
        bc = 1'b1;
        @(negedge pclk);
        check("break_txd_low", txd, 1'b0);
        cycles(8);
        bc = 1'b0;
        wait_idle();
        check_int("break_done_pulses", done_cnt - d0, 1);

        // Randomized frames, mixing idle gaps and back-to-back writes
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(2, 0) == 0)
                cycles($urandom_range(40, 1));
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
            wait_load();
        end
        wait_idle();

        // Reset mid-frame with a byte pending in the THR
        send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_load();
        send(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(16);
        preset = 1'b1;
        cycles(1);
        preset = 1'b0;
        @(negedge pclk);
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_thr_ready", thr_ready, 1'b1);
        check("rst_mid_tx_busy", tx_busy, 1'b0);
        check("rst_mid_tx_empty", tx_empty, 1'b1);
        d0 = done_cnt;
        c0 = clr_cnt;
        cycles(80);
        check_int("rst_mid_no_done", done_cnt - d0, 0);
        check_int("rst_mid_no_clr", clr_cnt - c0, 0);
        check("rst_mid_txd_idle", txd, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
